// File: rtl/cipher_sequencer.sv
// Sequencer for a multi-cycle cipher core: key load, block load, wait for CF or timeout,
// result capture and handshake, then a fixed idle gap before the next request.
//   state  | meaning
//   IDLE   | waiting for key or block
//   KEYLD  | cu_CK pulsed while the cipher loads the key
//   LOAD   | cipher samples cu_state_i
//   RUN    | waiting for cu_CF or timeout
//   SETTLE | cipher output settles before capture
//   DONE   | result presented on out_valid
//   GAP    | enforced idle after a result
module cipher_sequencer #(
  parameter int unsigned MAX_WAIT   = 20000,
  parameter int unsigned CK_CYCLES  = 2,
  parameter int unsigned GAP_CYCLES = 100
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [7:0][31:0]  key_i,
  input  logic [1:0]        kl_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0][31:0]  blk_i,
  input  logic              enc_dec_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0][31:0]  blk_o,
  output logic              out_err,
  output logic [15:0]       cycles_o,
  output logic              cu_CLR,
  output logic              cu_CK,
  output logic [7:0][31:0]  cu_KEY,
  output logic [1:0]        cu_KL,
  output logic              cu_enc_dec,
  output logic [3:0][31:0]  cu_state_i,
  input  logic [3:0][31:0]  cu_state_o,
  input  logic              cu_CF,
  output logic              key_loaded
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_KEYLD  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_GAP    = 3'd6;

  localparam logic [31:0] CK_LD    = (CK_CYCLES > 0) ? 32'(CK_CYCLES - 1) : 32'd0;
  localparam logic [31:0] GAP_LD   = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
  localparam logic [31:0] WAIT_LIM = 32'(MAX_WAIT);

  logic [2:0]        r_state;
  logic [31:0]       r_tmr;
  logic [31:0]       r_cnt;
  logic              r_clr_q;
  logic              r_key_loaded;
  logic              r_out_err;
  logic [15:0]       r_cycles;
  logic [3:0][31:0]  r_blk;
  logic [7:0][31:0]  r_key;
  logic [1:0]        r_kl;
  logic              r_ed;
  logic [3:0][31:0]  r_st;
  logic [31:0]       w_cnt_nxt;
  logic              w_idle;

  assign w_cnt_nxt = r_cnt + 32'd1;
  assign w_idle    = (r_state == S_IDLE) && !CLR;

  // Handshake readies are gated by CLR so they read 0 for the whole reset pulse.
  assign key_ready  = w_idle;
  assign in_ready   = w_idle && r_key_loaded && !key_valid;
  assign out_valid  = (r_state == S_DONE);
  assign cu_CK      = CLR || (r_state == S_KEYLD);
  assign cu_CLR     = CLR || r_clr_q;
  assign blk_o      = r_blk;
  assign out_err    = r_out_err;
  assign cycles_o   = r_cycles;
  assign cu_KEY     = r_key;
  assign cu_KL      = r_kl;
  assign cu_enc_dec = r_ed;
  assign cu_state_i = r_st;
  assign key_loaded = r_key_loaded;

  always_ff @(posedge CLK) begin
    r_clr_q <= CLR;
    if (CLR) begin
      r_state      <= S_IDLE;
      r_tmr        <= '0;
      r_cnt        <= '0;
      r_key_loaded <= 1'b0;
      r_out_err    <= 1'b0;
      r_cycles     <= '0;
      r_blk        <= '0;
      r_key        <= '0;
      r_kl         <= '0;
      r_ed         <= 1'b0;
      r_st         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (key_valid) begin
            r_key   <= key_i;
            r_kl    <= kl_i;
            r_tmr   <= CK_LD;
            r_state <= S_KEYLD;
          end else if (in_valid && r_key_loaded) begin
            r_st    <= blk_i;
            r_ed    <= enc_dec_i;
            r_state <= S_LOAD;
          end
        end
        S_KEYLD: begin
          if (r_tmr == 32'd0) begin
            r_key_loaded <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_tmr <= r_tmr - 32'd1;
          end
        end
        S_LOAD: begin
          r_cnt   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_cnt <= w_cnt_nxt;
          if (cu_CF) begin
            r_out_err <= 1'b0;
            r_state   <= S_SETTLE;
          end else if (w_cnt_nxt >= WAIT_LIM) begin
            r_out_err <= 1'b1;
            r_state   <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          r_blk    <= cu_state_o;
          r_cycles <= (r_cnt > 32'h0000_FFFF) ? 16'hFFFF : r_cnt[15:0];
          r_state  <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            if (GAP_CYCLES == 0) begin
              r_state <= S_IDLE;
            end else begin
              r_tmr   <= GAP_LD;
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_tmr == 32'd0) r_state <= S_IDLE;
          else                r_tmr   <= r_tmr - 32'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_sequencer.sv
// Bench for cipher_sequencer: behavioural cipher stub with programmable CF latency,
// scoreboard of expected results checked when out_valid rises.
module tb_cipher_sequencer;
  localparam int MW  = 50;
  localparam int CK  = 2;
  localparam int GAP = 4;
  localparam logic [127:0] PT   = 128'h54776F20_4F6E6520_4E696E65_2054776F;
  localparam logic [127:0] CT   = 128'h29C3505F_571420F6_402299B3_1A02D73A;
  localparam logic [255:0] AKEY = {128'h54686174_73206D79_204B756E_67204675, 128'h0};

  logic CLK = 1'b0;
  logic CLR = 1'b1;
  logic key_valid = 1'b0, key_ready;
  logic [7:0][31:0] key_i = '0;
  logic [1:0] kl_i = '0;
  logic in_valid = 1'b0, in_ready;
  logic [3:0][31:0] blk_i = '0;
  logic enc_dec_i = 1'b0;
  logic out_valid, out_ready = 1'b1;
  logic [3:0][31:0] blk_o;
  logic out_err;
  logic [15:0] cycles_o;
  logic cu_CLR, cu_CK, cu_enc_dec, cu_CF, key_loaded;
  logic [7:0][31:0] cu_KEY;
  logic [1:0] cu_KL;
  logic [3:0][31:0] cu_state_i, cu_state_o;

  cipher_sequencer #(.MAX_WAIT(MW), .CK_CYCLES(CK), .GAP_CYCLES(GAP)) dut (
    .CLK(CLK), .CLR(CLR),
    .key_valid(key_valid), .key_ready(key_ready), .key_i(key_i), .kl_i(kl_i),
    .in_valid(in_valid), .in_ready(in_ready), .blk_i(blk_i), .enc_dec_i(enc_dec_i),
    .out_valid(out_valid), .out_ready(out_ready), .blk_o(blk_o), .out_err(out_err),
    .cycles_o(cycles_o), .cu_CLR(cu_CLR), .cu_CK(cu_CK), .cu_KEY(cu_KEY), .cu_KL(cu_KL),
    .cu_enc_dec(cu_enc_dec), .cu_state_i(cu_state_i), .cu_state_o(cu_state_o),
    .cu_CF(cu_CF), .key_loaded(key_loaded)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Cipher stub: known AES vector for the reference key, otherwise a simple keyed mix.
  function automatic logic [127:0] stub_f(input logic [127:0] st, input logic ed, input logic [255:0] k);
    if (k == AKEY && ed && st == PT) return CT;
    if (k == AKEY && !ed && st == CT) return PT;
    if (ed) return st ^ k[127:0] ^ {4{32'h0F0F1234}};
    return {st[63:0], st[127:64]} ^ k[255:128];
  endfunction

  int stub_lat = 2;
  bit stub_kill = 0;
  bit st_busy = 0;
  int st_cnt = 0;
  always @(negedge CLK) begin
    if (CLR) st_busy <= 1'b0;
    else if (in_valid && in_ready) begin
      st_busy <= !stub_kill;
      st_cnt  <= stub_lat;
    end else if (st_busy) begin
      if (st_cnt == 0) st_busy <= 1'b0;
      else st_cnt <= st_cnt - 1;
    end
  end
  assign cu_CF      = st_busy && (st_cnt == 0);
  assign cu_state_o = stub_f(cu_state_i, cu_enc_dec, cu_KEY);

  typedef struct { logic [127:0] blk; logic err; logic [15:0] ncyc; int vcyc; } exp_t;
  exp_t sb[$];
  exp_t e_mon;
  bit prev_ov = 0;
  logic [127:0] held;

  always @(negedge CLK) begin
    if (out_valid === 1'b1 && !prev_ov) begin
      if (sb.size() == 0) chk("ov_spurious", out_valid, 0);
      else begin
        e_mon = sb.pop_front();
        chk("latency", cyc, e_mon.vcyc);
        chk("blk_o", blk_o, e_mon.blk);
        chk("out_err", out_err, e_mon.err);
        chk("cycles_o", cycles_o, e_mon.ncyc);
      end
      held = blk_o;
    end else if (out_valid === 1'b1) begin
      chk("blk_hold", blk_o, held);
    end
    prev_ov = (out_valid === 1'b1);
  end

  logic [255:0] cur_key;

  task automatic send(input logic [127:0] blk, input logic ed, input int lat, input bit kill,
                      input logic [127:0] exp_blk);
    exp_t e;
    @(posedge CLK); #1;
    blk_i = blk; enc_dec_i = ed; stub_lat = lat; stub_kill = kill; in_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      if (in_ready) break;
    end
    chk("accept", in_ready, 1);
    e.blk  = exp_blk;
    e.err  = kill;
    e.ncyc = kill ? 16'(MW) : 16'(lat - 1);
    e.vcyc = kill ? cyc + MW + 3 : cyc + lat + 2;
    if (in_ready) sb.push_back(e);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    chk("cu_state_i", cu_state_i, blk);
    chk("cu_enc_dec", cu_enc_dec, ed);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || out_valid === 1'b1) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_in_budget", n < budget, 1);
  endtask

  task automatic load_key(input logic [255:0] k, input logic [1:0] kl);
    @(posedge CLK); #1;
    key_i = k; kl_i = kl; key_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      if (key_ready) break;
    end
    chk("key_accept", key_ready, 1);
    @(posedge CLK); #1;
    key_valid = 1'b0;
    for (int i = 0; i < CK; i++) begin
      @(negedge CLK);
      chk("keyld_ck_hi", cu_CK, 1);
      chk("keyld_kr_lo", key_ready, 0);
    end
    @(negedge CLK);
    chk("keyld_ck_lo", cu_CK, 0);
    chk("key_loaded", key_loaded, 1);
    chk("cu_KEY", cu_KEY, k);
    chk("cu_KL", cu_KL, kl);
    cur_key = k;
  endtask

  task automatic gap_check();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (out_valid !== 1'b1 && n < 200);
    chk("gap_ov_seen", out_valid, 1);
    for (int i = 0; i < GAP; i++) begin
      @(negedge CLK);
      chk("gap_kr", key_ready, 0);
      chk("gap_ir", in_ready, 0);
      chk("gap_ov", out_valid, 0);
    end
    @(negedge CLK);
    chk("gap_end_kr", key_ready, 1);
  endtask

  initial begin
    logic [127:0] b;
    logic [255:0] k2;
    logic ed;
    int lat;
    bit ov_seen;

    repeat (3) @(negedge CLK);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_key_ready", key_ready, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_key_loaded", key_loaded, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_cycles_o", cycles_o, 0);
    chk("rst_blk_o", blk_o, 0);
    chk("rst_cu_CK", cu_CK, 1);
    chk("rst_cu_CLR", cu_CLR, 1);
    chk("rst_cu_state_i", cu_state_i, 0);
    chk("rst_cu_KEY", cu_KEY, 0);
    chk("rst_cu_KL", cu_KL, 0);
    chk("rst_cu_enc_dec", cu_enc_dec, 0);
    @(posedge CLK); #1;
    CLR = 1'b0;
    @(negedge CLK);
    chk("post_rst_kr", key_ready, 1);
    chk("post_rst_ck", cu_CK, 0);
    chk("post_rst_cuclr", cu_CLR, 1);
    chk("post_rst_ir", in_ready, 0);
    @(negedge CLK);
    chk("cuclr_drop", cu_CLR, 0);

    load_key(AKEY, 2'd1);
    send(PT, 1'b1, 10, 0, CT);
    gap_check();
    send(CT, 1'b0, 7, 0, PT);
    drain(300);

    for (int i = 0; i < 4; i++) begin
      b   = {$urandom, $urandom, $urandom, $urandom};
      ed  = 1'($urandom_range(0, 1));
      lat = $urandom_range(2, 40);
      send(b, ed, lat, 0, stub_f(b, ed, cur_key));
    end
    drain(600);

    b = {$urandom, $urandom, $urandom, $urandom};
    send(b, 1'b1, 2, 1, stub_f(b, 1'b1, cur_key));
    drain(300);

    // Key and block offered together: key wins, block follows after the key load.
    k2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b  = {$urandom, $urandom, $urandom, $urandom};
    @(posedge CLK); #1;
    key_i = k2; kl_i = 2'd2; key_valid = 1'b1;
    blk_i = b; enc_dec_i = 1'b1; stub_lat = 5; stub_kill = 0; in_valid = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      if (key_ready) break;
    end
    chk("both_kr", key_ready, 1);
    chk("both_ir", in_ready, 0);
    @(posedge CLK); #1;
    key_valid = 1'b0;
    for (int i = 0; i < CK; i++) begin
      @(negedge CLK);
      chk("both_ir_hold", in_ready, 0);
    end
    @(negedge CLK);
    chk("both_ir_up", in_ready, 1);
    chk("both_cu_KEY", cu_KEY, k2);
    begin
      exp_t e;
      e.blk = stub_f(b, 1'b1, k2); e.err = 1'b0; e.ncyc = 16'd4; e.vcyc = cyc + 7;
      sb.push_back(e);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    cur_key = k2;
    drain(300);

    // Output back-pressure: result must hold and nothing new may be accepted.
    out_ready = 1'b0;
    b = {$urandom, $urandom, $urandom, $urandom};
    send(b, 1'b0, 3, 0, stub_f(b, 1'b0, cur_key));
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (out_valid !== 1'b1 && lat < 200);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk("bp_ov", out_valid, 1);
      chk("bp_ir", in_ready, 0);
      chk("bp_cu_state_i", cu_state_i, b);
    end
    @(posedge CLK); #1;
    out_ready = 1'b1;
    drain(300);

    // Reset pulsed in the middle of RUN discards the block.
    b = {$urandom, $urandom, $urandom, $urandom};
    send(b, 1'b1, 30, 0, stub_f(b, 1'b1, cur_key));
    repeat (8) @(posedge CLK);
    #1;
    CLR = 1'b1;
    sb.delete();
    @(negedge CLK);
    chk("midrun_cuclr", cu_CLR, 1);
    chk("midrun_ck", cu_CK, 1);
    chk("midrun_kr", key_ready, 0);
    @(posedge CLK); #1;
    CLR = 1'b0;
    ov_seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      ov_seen |= (out_valid === 1'b1);
    end
    chk("midrun_no_ov", ov_seen, 0);
    chk("midrun_key_loaded", key_loaded, 0);
    chk("midrun_ir", in_ready, 0);
    chk("midrun_kr_back", key_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/cipher_sequencer.md
CIPHER_SEQUENCER -- requirements
Module: cipher_sequencer

Interface
REQ-001 Parameter MAX_WAIT, default 20000: cycles waited for cipher CF before timeout.
REQ-002 Parameter CK_CYCLES, default 2: cycles cu_CK is held high during a key load.
REQ-003 Parameter GAP_CYCLES, default 100: idle cycles enforced after each result handshake.
REQ-004 CLK  in  1  single clock, all logic on posedge.
REQ-005 CLR  in  1  reset, synchronous, active-high.
REQ-006 key_valid / key_ready  in / out  1 / 1  key-load handshake.
REQ-007 key_i [7:0]  in  32 each  key words; kl_i  in  2  key-length code.
REQ-008 in_valid / in_ready  in / out  1 / 1  block-input handshake.
REQ-009 blk_i [3:0]  in  32 each  input block, [3] first word; enc_dec_i  in  1  1=encrypt, 0=decrypt.
REQ-010 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-011 blk_o [3:0]  out  32 each  result block; out_err  out  1  result produced by timeout, not CF.
REQ-012 cycles_o  out  16  RUN cycles counted for the last block, saturating at 16'hFFFF.
REQ-013 cu_CLR, cu_CK  out  1 each; cu_KEY [7:0]  out  32 each; cu_KL  out  2; cu_enc_dec  out  1; cu_state_i [3:0]  out  32 each: drive cipher_unit.
REQ-014 cu_state_o [3:0]  in  32 each; cu_CF  in  1: observed from cipher_unit.
REQ-015 key_loaded  out  1  a key has been loaded since reset.

Function
REQ-016 States: IDLE, KEYLD, LOAD, RUN, SETTLE, DONE, GAP; one-hot or binary, no other reachable states.
REQ-017 key_ready=1 only in IDLE; in_ready=1 only in IDLE with key_loaded=1 and key_valid=0.
REQ-018 IDLE & key_valid: latch key_i/kl_i into cu_KEY/cu_KL, go KEYLD; key takes priority over a simultaneous in_valid.
REQ-019 KEYLD: cu_CK=1 for exactly CK_CYCLES cycles, then cu_CK=0, key_loaded=1, go IDLE.
REQ-020 IDLE & in_valid & in_ready: latch blk_i to cu_state_i and enc_dec_i to cu_enc_dec, go LOAD.
REQ-021 LOAD lasts exactly 1 cycle (cipher samples cu_state_i), then RUN with wait counter cleared.
REQ-022 RUN: counter increments each cycle; cu_CF===1 -> SETTLE, out_err cleared; counter == MAX_WAIT -> SETTLE, out_err set.
REQ-023 SETTLE lasts 1 cycle; at its end capture cu_state_o into blk_o and the counter into cycles_o, go DONE.
REQ-024 Latency: accept at cycle T, RUN entered at T+2; CF first seen at cycle C gives out_valid=1 at C+2.
REQ-025 DONE: out_valid=1, blk_o/out_err stable until out_valid & out_ready; then out_valid=0, go GAP.
REQ-026 GAP: exactly GAP_CYCLES cycles with all ready outputs 0, then IDLE; GAP_CYCLES=0 goes directly to IDLE.
REQ-027 cu_state_i, cu_KEY, cu_KL, cu_enc_dec held constant from latch until the next latch.
REQ-028 cu_CLR=1 while CLR=1 and for the first cycle after CLR deasserts, otherwise 0.
REQ-029 Key reload is permitted only from IDLE; cu_CK is never asserted outside KEYLD or reset.

Reset
REQ-030 CLR=1 at any state, including mid-RUN: next state IDLE; pending block discarded, no out_valid produced.
REQ-031 Reset values: out_valid=0, key_ready=0, in_ready=0, key_loaded=0, out_err=0, cycles_o=0, blk_o=0, cu_CK=1, cu_CLR=1, cu_state_i=0, cu_KEY=0, cu_KL=0, cu_enc_dec=0.
REQ-032 First cycle after CLR deasserts: key_ready=1, cu_CK=0.

Verification
REQ-033 Reset, load key 54686174 73206D79 204B756E 67204675 with KL=1, then encrypt 54776F20 4F6E6520 4E696E65 2054776F -> blk_o=29C3505F 571420F6 402299B3 1A02D73A, out_err=0.
REQ-034 Same key, decrypt 29C3505F 571420F6 402299B3 1A02D73A -> blk_o=54776F20 4F6E6520 4E696E65 2054776F.
REQ-035 Stub cipher with CF tied 0, MAX_WAIT=50 -> out_valid at accept+53, out_err=1, cycles_o=50.
REQ-036 key_valid and in_valid both high in IDLE -> key accepted first, in_ready=0 for CK_CYCLES+1 cycles, block accepted after.
REQ-037 out_ready held 0 for 10 cycles in DONE -> blk_o stable and no new block accepted; CLR pulsed mid-RUN -> out_valid never asserts, key_loaded=0.
